// File: rtl/demux2b16_stage_pkg.sv
// Shared definitions for the demux2b16_stage block.
//   DATAPATH_W   : width of the 16-bit datapath
//   SEL_A/SEL_B  : encoding of the destination select S
//   slot_state_t : state of one output register slot
// Optional feature macro: DEMUX2B16_COUNT_EN (drain counters on each slot).
package demux2b16_stage_pkg;

  localparam int DATAPATH_W = 16;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/demux2b16_stage_if.sv
// Handshake bundle for demux2b16_stage.
//   I, S, IN_VALID / IN_READY      : source word, destination select, handshake
//   OA, OA_VALID / OA_READY        : destination A data and handshake
//   OB, OB_VALID / OB_READY        : destination B data and handshake
// Modports: slave = the demux itself, master = source plus both consumers.
// Optional feature macro: DEMUX2B16_COUNT_EN (counters are plain top ports).
interface demux2b16_stage_if
  import demux2b16_stage_pkg::*;
#(
  parameter int WIDTH = DATAPATH_W
) ();

  logic [WIDTH-1:0] I;
  logic             S;
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] OA;
  logic             OA_VALID;
  logic             OA_READY;
  logic [WIDTH-1:0] OB;
  logic             OB_VALID;
  logic             OB_READY;

  modport slave (
    input  I, S, IN_VALID, OA_READY, OB_READY,
    output IN_READY, OA, OA_VALID, OB, OB_VALID
  );

  modport master (
    output I, S, IN_VALID, OA_READY, OB_READY,
    input  IN_READY, OA, OA_VALID, OB, OB_VALID
  );

endinterface

// File: rtl/demux2b16_stage_demux_out_slot.sv
// One-entry output register slot of the demux.
//   clk, rst  : clock and synchronous active-high reset
//   load      : write load_data into the slot this edge
//   load_data : word to store
//   ready     : consumer takes the word held in the slot
//   data      : held word (registered)
//   valid     : slot holds an undelivered word (registered)
//   full      : slot state is FULL
//   drain     : the held word is consumed this cycle
//   cnt       : drain counter, only with DEMUX2B16_COUNT_EN
module demux_out_slot
  import demux2b16_stage_pkg::*;
#(
  parameter int               WIDTH     = DATAPATH_W,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_data,
  input  logic                  ready,
  output logic [WIDTH-1:0]      data,
  output logic                  valid,
  output logic                  full,
  output logic                  drain
`ifdef DEMUX2B16_COUNT_EN
  ,
  output logic [DATAPATH_W-1:0] cnt
`endif
);

  slot_state_t      state_r;
  logic [WIDTH-1:0] data_r;
  logic             valid_r;
  logic             drain_s;

  assign drain_s = valid_r & ready;
  assign drain   = drain_s;
  assign full    = (state_r == SLOT_FULL);
  assign data    = data_r;
  assign valid   = valid_r;

  // Slot FSM: a load always wins over a drain, so simultaneous drain+load keeps the slot FULL with new data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= SLOT_EMPTY;
      data_r  <= RESET_VAL;
      valid_r <= 1'b0;
    end else begin
      case (state_r)
        SLOT_EMPTY: begin
          if (load) begin
            state_r <= SLOT_FULL;
            data_r  <= load_data;
            valid_r <= 1'b1;
          end
        end
        SLOT_FULL: begin
          if (load) begin
            data_r  <= load_data;
          end else if (drain_s) begin
            state_r <= SLOT_EMPTY;
            valid_r <= 1'b0;
          end
        end
        default: begin
          state_r <= SLOT_EMPTY;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef DEMUX2B16_COUNT_EN
  logic [DATAPATH_W-1:0] cnt_r;

  // Drain counter; wraps naturally at the register width, reset takes priority over a drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {DATAPATH_W{1'b0}};
    end else if (drain_s) begin
      cnt_r <= cnt_r + {{(DATAPATH_W-1){1'b0}}, 1'b1};
    end
  end

  assign cnt = cnt_r;
`endif

endmodule

// File: rtl/demux2b16_stage.sv
// Registered 1-to-2 demultiplexer: routes word I to destination A (S=0) or
// B (S=1), each destination behind its own one-entry register slot.
//   CLK, RST : clock and synchronous active-high reset
//   bus      : demux2b16_stage_if.slave (I/S/IN_VALID/IN_READY, OA*, OB*)
//   CNT_A/B  : per-destination drain counters, only with DEMUX2B16_COUNT_EN
// IN_READY is combinational: it looks at the selected slot only, so a stalled
// destination never blocks traffic to the other one.
module demux2b16_stage
  import demux2b16_stage_pkg::*;
#(
  parameter int               WIDTH     = DATAPATH_W,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                  CLK,
  input  logic                  RST,
  demux2b16_stage_if.slave      bus
`ifdef DEMUX2B16_COUNT_EN
  ,
  output logic [DATAPATH_W-1:0] CNT_A,
  output logic [DATAPATH_W-1:0] CNT_B
`endif
);

  logic in_ready_s;
  logic load_a_s;
  logic load_b_s;
  logic full_a_s;
  logic full_b_s;
  logic drain_a_s;
  logic drain_b_s;

  // Select decode: ready when the chosen slot is empty or frees up this cycle; loads need a real accept.
  always_comb begin
    in_ready_s = 1'b0;
    load_a_s   = 1'b0;
    load_b_s   = 1'b0;
    if (bus.S == SEL_B) begin
      in_ready_s = ~full_b_s | drain_b_s;
    end else begin
      in_ready_s = ~full_a_s | drain_a_s;
    end
    if (bus.IN_VALID && in_ready_s) begin
      if (bus.S == SEL_B) begin
        load_b_s = 1'b1;
      end else begin
        load_a_s = 1'b1;
      end
    end else begin
      load_a_s = 1'b0;
      load_b_s = 1'b0;
    end
  end

  assign bus.IN_READY = in_ready_s;

  demux_out_slot #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_slot_a (
    .clk       (CLK),
    .rst       (RST),
    .load      (load_a_s),
    .load_data (bus.I),
    .ready     (bus.OA_READY),
    .data      (bus.OA),
    .valid     (bus.OA_VALID),
    .full      (full_a_s),
    .drain     (drain_a_s)
`ifdef DEMUX2B16_COUNT_EN
    ,
    .cnt       (CNT_A)
`endif
  );

  demux_out_slot #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_slot_b (
    .clk       (CLK),
    .rst       (RST),
    .load      (load_b_s),
    .load_data (bus.I),
    .ready     (bus.OB_READY),
    .data      (bus.OB),
    .valid     (bus.OB_VALID),
    .full      (full_b_s),
    .drain     (drain_b_s)
`ifdef DEMUX2B16_COUNT_EN
    ,
    .cnt       (CNT_B)
`endif
  );

endmodule

// File: tb/tb_demux2b16_stage.sv
// Self-checking bench for demux2b16_stage: accepted words are pushed into a
// per-destination expected queue; a monitor pops and compares on every drain.
// Directed checks cover reset, stalls, back-pressure and reset mid-transfer.
// With DEMUX2B16_COUNT_EN defined it also checks the drain counters.
module tb_demux2b16_stage;
  import demux2b16_stage_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [15:0] exp_a_q[$];
  logic [15:0] exp_b_q[$];

  demux2b16_stage_if #(.WIDTH(16)) bus ();

`ifdef DEMUX2B16_COUNT_EN
  logic [15:0] cnt_a;
  logic [15:0] cnt_b;
`endif

  demux2b16_stage #(.WIDTH(16), .RESET_VAL(16'h0000)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
`ifdef DEMUX2B16_COUNT_EN
    ,
    .CNT_A (cnt_a),
    .CNT_B (cnt_b)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: every cycle a slot drains, its word must be the oldest expected one for that slot.
  always @(negedge CLK) begin
    if (!RST) begin
      if (bus.OA_VALID && bus.OA_READY) begin
        if (exp_a_q.size() == 0) begin
          total++; bad++;
          $display("FAIL mon_a: unexpected word %0h", bus.OA);
        end else begin
          check("mon_a", {16'h0000, bus.OA}, {16'h0000, exp_a_q.pop_front()});
        end
      end
      if (bus.OB_VALID && bus.OB_READY) begin
        if (exp_b_q.size() == 0) begin
          total++; bad++;
          $display("FAIL mon_b: unexpected word %0h", bus.OB);
        end else begin
          check("mon_b", {16'h0000, bus.OB}, {16'h0000, exp_b_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    bus.I = 16'h0000; bus.S = 1'b0; bus.IN_VALID = 1'b0;
    bus.OA_READY = 1'b0; bus.OB_READY = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;

    // reset state
    check("rst_oa_valid", {31'd0, bus.OA_VALID}, 32'd0);
    check("rst_ob_valid", {31'd0, bus.OB_VALID}, 32'd0);
    check("rst_oa", {16'h0000, bus.OA}, 32'h0000_0000);
    check("rst_ob", {16'h0000, bus.OB}, 32'h0000_0000);
    check("rst_in_ready", {31'd0, bus.IN_READY}, 32'd1);

    // single word to A
    bus.OA_READY = 1'b1;
    bus.S = SEL_A; bus.I = 16'h0005; bus.IN_VALID = 1'b1;
    exp_a_q.push_back(16'h0005);
    step();
    bus.IN_VALID = 1'b0;
    check("a1_oa", {16'h0000, bus.OA}, 32'h0000_0005);
    check("a1_oa_valid", {31'd0, bus.OA_VALID}, 32'd1);
    check("a1_ob_valid", {31'd0, bus.OB_VALID}, 32'd0);
    check("a1_in_ready", {31'd0, bus.IN_READY}, 32'd1);
    step();

    // B stall, then drain+load on the same edge
    bus.S = SEL_B; bus.I = 16'h000A; bus.IN_VALID = 1'b1;
    exp_b_q.push_back(16'h000A);
    step();
    check("b1_ob", {16'h0000, bus.OB}, 32'h0000_000A);
    check("b1_ob_valid", {31'd0, bus.OB_VALID}, 32'd1);
    bus.I = 16'h00FF;
    #1;
    check("b2_stall_ready", {31'd0, bus.IN_READY}, 32'd0);
    step();
    check("b2_hold_ob", {16'h0000, bus.OB}, 32'h0000_000A);
    check("b2_hold_valid", {31'd0, bus.OB_VALID}, 32'd1);
    bus.OB_READY = 1'b1;
    #1;
    check("b2_ready_on_drain", {31'd0, bus.IN_READY}, 32'd1);
    exp_b_q.push_back(16'h00FF);
    step();
    bus.IN_VALID = 1'b0;
    check("b2_ob_new", {16'h0000, bus.OB}, 32'h0000_00FF);
    check("b2_ob_valid", {31'd0, bus.OB_VALID}, 32'd1);
    step();
    bus.OB_READY = 1'b0;

    // B stalled full, stream 1,2,3 to A
    bus.S = SEL_B; bus.I = 16'h0077; bus.IN_VALID = 1'b1;
    exp_b_q.push_back(16'h0077);
    step();
    for (int k = 1; k <= 3; k++) begin
      bus.S = SEL_A; bus.I = k[15:0];
      #1;
      check("str_in_ready", {31'd0, bus.IN_READY}, 32'd1);
      exp_a_q.push_back(k[15:0]);
      step();
      check("str_oa", {16'h0000, bus.OA}, k);
      check("str_oa_valid", {31'd0, bus.OA_VALID}, 32'd1);
    end
    bus.IN_VALID = 1'b0;
    check("str_ob_kept", {16'h0000, bus.OB}, 32'h0000_0077);
    check("str_ob_valid", {31'd0, bus.OB_VALID}, 32'd1);
    step();

    // both full, then reset with a pending load
    bus.OA_READY = 1'b0;
    bus.S = SEL_A; bus.I = 16'h0011; bus.IN_VALID = 1'b1;
    exp_a_q.push_back(16'h0011);
    step();
    check("full_ready_s0", {31'd0, bus.IN_READY}, 32'd0);
    bus.S = SEL_B;
    #1;
    check("full_ready_s1", {31'd0, bus.IN_READY}, 32'd0);
    bus.OA_READY = 1'b1; bus.OB_READY = 1'b1;
    RST = 1'b1;
    step();
    exp_a_q.delete();
    exp_b_q.delete();
    RST = 1'b0;
    bus.IN_VALID = 1'b0;
    check("mid_rst_oa_valid", {31'd0, bus.OA_VALID}, 32'd0);
    check("mid_rst_ob_valid", {31'd0, bus.OB_VALID}, 32'd0);
    check("mid_rst_oa", {16'h0000, bus.OA}, 32'h0000_0000);
    check("mid_rst_ob", {16'h0000, bus.OB}, 32'h0000_0000);
    check("mid_rst_in_ready", {31'd0, bus.IN_READY}, 32'd1);

    // IN_VALID low: I/S activity must not load anything
    for (int k = 0; k < 4; k++) begin
      bus.S = k[0]; bus.I = 16'hBEE0 + k[15:0];
      if (k == 3) begin
        bus.S = 1'bx; bus.I = 16'hxxxx;
      end
      step();
      check("idle_oa_valid", {31'd0, bus.OA_VALID}, 32'd0);
      check("idle_ob_valid", {31'd0, bus.OB_VALID}, 32'd0);
      check("idle_oa", {16'h0000, bus.OA}, 32'h0000_0000);
      check("idle_ob", {16'h0000, bus.OB}, 32'h0000_0000);
    end
    bus.S = SEL_A; bus.I = 16'h0000;

`ifdef DEMUX2B16_COUNT_EN
    // 65537 drains on A: the counter wraps once and ends at 1
    bus.OA_READY = 1'b1; bus.OB_READY = 1'b1;
    bus.S = SEL_A; bus.IN_VALID = 1'b1;
    for (int k = 0; k < 65537; k++) begin
      bus.I = k[15:0];
      exp_a_q.push_back(k[15:0]);
      step();
    end
    bus.IN_VALID = 1'b0;
    step();
    check("cnt_a_wrap", {16'h0000, cnt_a}, 32'h0000_0001);
    check("cnt_b_zero", {16'h0000, cnt_b}, 32'h0000_0000);
`endif

    step();
    check("q_a_drained", exp_a_q.size(), 32'd0);
    check("q_b_drained", exp_b_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux2b16_stage.md
Name: demux2b16_stage

Overview:
- Registered 1-to-2 demultiplexer for the 16-bit datapath; the inverse of the 2:1 select mux (A/B in, S, O out).
- Routes one source word I to destination A or B by select S, using a valid/ready handshake on the input and on each output.
- Each output has a one-entry register slot, so a stalled destination does not corrupt the other path.
- Sits between a shared result bus and two consumers (e.g. register-file write port and memory write-data path).

Parameters:
- WIDTH, 16, data width of I, OA, OB.
- RESET_VAL, 0, value loaded into OA/OB data registers on reset.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous reset, active-high.
- I  input  WIDTH  source data word.
- S  input  1  destination select: 0 selects A, 1 selects B.
- IN_VALID  input  1  source presents a valid word on I/S.
- IN_READY  output  1  block accepts I this cycle.
- OA  output  WIDTH  destination A data.
- OA_VALID  output  1  OA holds an undelivered word.
- OA_READY  input  1  destination A consumes OA.
- OB  output  WIDTH  destination B data.
- OB_VALID  output  1  OB holds an undelivered word.
- OB_READY  input  1  destination B consumes OB.

Behaviour:
- One clock (CLK); reset RST is synchronous and active-high.
- Reset: OA=OB=RESET_VAL, OA_VALID=OB_VALID=0, both slots EMPTY. IN_READY=1 in the first cycle after reset.
- Per-slot FSM (A and B identical): EMPTY, FULL.
  - EMPTY to FULL on a load.
  - FULL to EMPTY on drain without load.
  - FULL to FULL on simultaneous drain and load; new data replaces old in the same edge.
- Drain on slot X: X_VALID & X_READY.
- Load on slot X: IN_VALID & IN_READY & (S selects X).
- Combinational IN_READY = (selected slot EMPTY) | (selected slot drains this cycle). It depends on S and the selected OX_READY only.
- Latency: accepted word appears on OX with OX_VALID=1 exactly 1 cycle after the accept edge. Throughput is 1 word/cycle per destination when its READY is held high.
- Data on OX is held stable while OX_VALID=1 and not drained. OX is not updated when not loaded; a stale value is retained.
- Non-selected slot is unaffected by input traffic and may drain in the same cycle.
- IN_VALID=0: no load, regardless of S or I (X and Z on I/S are ignored).
- Both slots FULL, neither draining: IN_READY=0 for either S. The source must hold I/S/IN_VALID.
- RST asserted mid-transfer: pending words are discarded and VALIDs drop to 0 at that edge, overriding any simultaneous load or drain.
- Order is preserved per destination. No ordering guarantee across A and B.

Optional Feature:
- Macro DEMUX2B16_COUNT_EN.
- Defined:
  - Adds outputs CNT_A and CNT_B, each 16 bits.
  - Each counter increments by 1 on every drain of its slot and wraps from 16'hFFFF to 0.
  - Both counters reset to 0 on RST.
  - A drain in the reset cycle is not counted.
- Undefined: ports and counters are absent; behaviour otherwise identical.

Decomposition:
- Shared package:
  - DATAPATH_W = 16.
  - Select encoding SEL_A = 1'b0, SEL_B = 1'b1.
  - Slot state typedef {SLOT_EMPTY, SLOT_FULL}.
- Sub-module demux_out_slot:
  - One register slot with load/drain/full, plus the optional counter.
  - Instantiated twice.
- Top level holds the select decode and IN_READY logic.

Test Plan:
- Reset then IN_VALID=1, S=0, I=16'h0005, OA_READY=1 -> next cycle OA=5, OA_VALID=1, OB_VALID=0; IN_READY stays 1.
- S=1, I=16'h000A, OB_READY=0 -> OB=A, OB_VALID=1. Second word 16'h00FF to B -> IN_READY=0, OB holds A. Raise OB_READY -> same edge drains A and loads FF.
- B stalled FULL, S=0 stream 1,2,3 with OA_READY=1 -> OA shows 1,2,3 on consecutive cycles; OB unchanged.
- Both slots FULL, READYs low -> IN_READY=0 for S=0 and S=1. Assert RST with IN_VALID=1 -> OA_VALID=OB_VALID=0 and OA=OB=0 next cycle.
- IN_VALID=0 with S and I toggling -> no VALID asserted, outputs unchanged.
- With DEMUX2B16_COUNT_EN: 65537 drains on A -> CNT_A=1; CNT_B=0.
